// File: rtl/alu_simd_accum_pipe.sv
// Two-stage SIMD / chained three-operand adder with P-register accumulate.
// Stage 1 registers operands and per-op control; stage 2 adds and loads P.
module alu_simd_accum_pipe #(
    parameter int unsigned LANES  = 2,
    parameter int unsigned LANE_W = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ce,
    input  logic                      in_valid,
    input  logic                      use_simd,
    input  logic                      acc_en,
    input  logic                      clr,
    input  logic [LANES*LANE_W-1:0]   W,
    input  logic [LANES*LANE_W-1:0]   X,
    input  logic [LANES*LANE_W-1:0]   Y,
    input  logic                      cin,
    output logic [LANES*LANE_W-1:0]   S,
    output logic [2*LANES-1:0]        carry_out,
    output logic                      out_valid
);

    localparam int unsigned TOTAL_W = LANES * LANE_W;

    logic [TOTAL_W-1:0] w_q, x_q, y_q;
    logic               cin_q, simd_q, acc_q, vld_q;

    logic [TOTAL_W-1:0] p_q, p_d;
    logic [2*LANES-1:0] cout_q, cout_d;
    logic               ovld_q, ovld_d;

    logic [TOTAL_W-1:0] sum_s;
    logic [2*LANES-1:0] sum_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_q    <= '0;
            x_q    <= '0;
            y_q    <= '0;
            cin_q  <= 1'b0;
            simd_q <= 1'b0;
            acc_q  <= 1'b0;
            vld_q  <= 1'b0;
        end else if (ce) begin
            w_q    <= W;
            x_q    <= X;
            y_q    <= Y;
            cin_q  <= cin;
            simd_q <= use_simd;
            acc_q  <= acc_en;
            vld_q  <= in_valid;
        end
    end

    // Lane carry ripples lane to lane in chained mode; this is the critical path.
    always_comb begin : stage2
        logic [1:0]        chain;
        logic [1:0]        lane_ci;
        logic [LANE_W-1:0] a_lane;
        logic [LANE_W+1:0] lane_sum;
        sum_s    = '0;
        sum_c    = '0;
        chain    = {1'b0, cin_q};
        lane_ci  = 2'b00;
        a_lane   = '0;
        lane_sum = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (clr)
                a_lane = '0;
            else if (acc_q)
                a_lane = p_q[k*LANE_W +: LANE_W];
            else
                a_lane = w_q[k*LANE_W +: LANE_W];
            lane_ci  = simd_q ? 2'b00 : chain;
            lane_sum = {2'b00, a_lane}
                     + {2'b00, x_q[k*LANE_W +: LANE_W]}
                     + {2'b00, y_q[k*LANE_W +: LANE_W]}
                     + {{LANE_W{1'b0}}, lane_ci};
            sum_s[k*LANE_W +: LANE_W] = lane_sum[LANE_W-1:0];
            sum_c[2*k +: 2]           = lane_sum[LANE_W+1:LANE_W];
            chain                     = lane_sum[LANE_W+1:LANE_W];
        end
    end

    always_comb begin
        p_d    = p_q;
        cout_d = cout_q;
        ovld_d = 1'b0;
        if (vld_q) begin
            p_d    = sum_s;
            cout_d = sum_c;
            ovld_d = 1'b1;
        end else if (clr) begin
            p_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_q    <= '0;
            cout_q <= '0;
            ovld_q <= 1'b0;
        end else if (ce) begin
            p_q    <= p_d;
            cout_q <= cout_d;
            ovld_q <= ovld_d;
        end
    end

    assign S         = p_q;
    assign carry_out = cout_q;
    assign out_valid = ovld_q;

endmodule

// File: tb/tb_alu_simd_accum_pipe.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// against a transaction-level arithmetic model of the accumulate pipe.
module tb_alu_simd_accum_pipe;

    localparam int unsigned LANES = 2;
    localparam int unsigned LW    = 16;
    localparam int unsigned TW    = LANES * LW;

    logic            clk = 1'b0;
    logic            reset, ce, in_valid, use_simd, acc_en, clr, cin;
    logic [TW-1:0]   W, X, Y, S;
    logic [2*LANES-1:0] carry_out;
    logic            out_valid;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    alu_simd_accum_pipe #(.LANES(LANES), .LANE_W(LW)) dut (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
        .use_simd(use_simd), .acc_en(acc_en), .clr(clr),
        .W(W), .X(X), .Y(Y), .cin(cin),
        .S(S), .carry_out(carry_out), .out_valid(out_valid)
    );

    typedef struct {
        bit          v, simd, acc, ci;
        logic [TW-1:0] w, x, y;
    } op_t;

    op_t                m_s1;
    logic [TW-1:0]      m_p;
    logic [2*LANES-1:0] m_c;
    bit                 m_ov;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // SIMD: each lane is its own add. Chained: lane k carry is the overflow of
    // the low (k+1) lanes taken as one wide number.
    function automatic void ref_add(input longint unsigned a, x, y, input bit ci, simd,
                                    output logic [TW-1:0] s, output logic [2*LANES-1:0] c);
        longint unsigned mask, part;
        c = '0;
        s = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            if (simd) begin
                mask = (64'd1 << LW) - 1;
                part = ((a >> (k*LW)) & mask) + ((x >> (k*LW)) & mask) + ((y >> (k*LW)) & mask);
                s[k*LW +: LW] = LW'(part);
                c[2*k +: 2]   = 2'(part >> LW);
            end else begin
                mask = (64'd1 << ((k+1)*LW)) - 1;
                part = (a & mask) + (x & mask) + (y & mask) + longint'(ci);
                c[2*k +: 2] = 2'(part >> ((k+1)*LW));
            end
        end
        if (!simd) s = TW'(a + x + y + longint'(ci));
    endfunction

    task automatic model_edge();
        longint unsigned a;
        logic [TW-1:0] ns;
        logic [2*LANES-1:0] nc;
        if (!ce) return;
        if (m_s1.v) begin
            a = clr ? 64'd0 : (m_s1.acc ? longint'(m_p) : longint'(m_s1.w));
            ref_add(a, longint'(m_s1.x), longint'(m_s1.y), m_s1.ci, m_s1.simd, ns, nc);
            m_p  = ns;
            m_c  = nc;
            m_ov = 1'b1;
        end else begin
            m_ov = 1'b0;
            if (clr) m_p = '0;
        end
        m_s1.v = in_valid; m_s1.simd = use_simd; m_s1.acc = acc_en; m_s1.ci = cin;
        m_s1.w = W; m_s1.x = X; m_s1.y = Y;
    endtask

    task automatic model_reset();
        m_s1 = '{v:1'b0, simd:1'b0, acc:1'b0, ci:1'b0, w:'0, x:'0, y:'0};
        m_p  = '0;
        m_c  = '0;
        m_ov = 1'b0;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("S", S, m_p);
        chk("carry_out", carry_out, m_c);
        chk("out_valid", out_valid, m_ov);
    endtask

    task automatic drive(input bit v, simd, acc, cl, ci, input logic [TW-1:0] w, x, y);
        in_valid = v; use_simd = simd; acc_en = acc; clr = cl; cin = ci;
        W = w; X = x; Y = y;
    endtask

    function automatic logic [TW-1:0] rnd_word();
        int unsigned sel;
        sel = $urandom_range(0, 5);
        if (sel == 0) return '0;
        if (sel == 1) return '1;
        return TW'($urandom);
    endfunction

    initial begin
        reset = 1'b1;
        ce    = 1'b1;
        drive(0, 0, 0, 0, 0, '0, '0, '0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_S", S, '0);
        chk("rst_cout", carry_out, '0);
        chk("rst_ov", out_valid, 1'b0);
        reset = 1'b0;

        // Chained carry across the lane boundary
        drive(1, 0, 0, 0, 0, 32'h0000FFFF, 32'h00000001, 32'h0);
        tick();
        drive(0, 0, 0, 0, 0, '0, '0, '0);
        tick();
        chk("chain_S", S, 32'h00010000);
        chk("chain_cout", carry_out, 4'b0001);
        chk("chain_ov", out_valid, 1'b1);
        tick();
        chk("chain_ov_drop", out_valid, 1'b0);

        // SIMD isolation, cin ignored
        drive(1, 1, 0, 0, 1, 32'h0000FFFF, 32'h00000001, 32'h0);
        tick();
        drive(0, 0, 0, 0, 0, '0, '0, '0);
        tick();
        chk("simd_S", S, 32'h00000000);
        chk("simd_cout", carry_out, 4'b0001);

        // Maximum operands, chained
        drive(1, 0, 0, 0, 1, '1, '1, '1);
        tick();
        drive(0, 0, 0, 0, 0, '0, '0, '0);
        tick();
        chk("max_S", S, 32'hFFFFFFFE);
        chk("max_cout", carry_out, 4'b1010);
        tick();

        // Accumulate: clear, four back-to-back acc ops, then clr on the fifth
        drive(0, 0, 0, 1, 0, '0, '0, '0);
        tick();
        chk("clr_S", S, '0);
        drive(1, 1, 1, 0, 0, 32'hDEADBEEF, 32'h00010001, 32'h0);
        tick();
        tick();
        chk("acc1", S, 32'h00010001);
        tick();
        chk("acc2", S, 32'h00020002);
        tick();
        chk("acc3", S, 32'h00030003);
        tick();
        chk("acc4", S, 32'h00040004);
        drive(0, 0, 0, 1, 0, '0, '0, '0);
        tick();
        chk("acc_clr", S, 32'h00010001);
        chk("acc_clr_ov", out_valid, 1'b1);

        // Stall with one op in stage 1
        drive(1, 1, 0, 0, 0, 32'd1, 32'd2, 32'd3);
        tick();
        drive(0, 0, 0, 0, 0, '0, '0, '0);
        ce = 1'b0;
        repeat (3) begin
            tick();
            chk("stall_S", S, 32'h00010001);
            chk("stall_ov", out_valid, 1'b0);
        end
        ce = 1'b1;
        tick();
        chk("stall_S_out", S, 32'h00000006);
        chk("stall_ov_out", out_valid, 1'b1);

        // Async reset with two ops in flight
        drive(1, 0, 0, 0, 1, 32'h12345678, 32'h11111111, 32'h22222222);
        tick();
        drive(1, 1, 0, 0, 0, 32'hAAAA5555, 32'h01010101, 32'h0F0F0F0F);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("arst_S", S, '0);
        chk("arst_cout", carry_out, '0);
        chk("arst_ov", out_valid, 1'b0);
        drive(0, 0, 0, 0, 0, '0, '0, '0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        repeat (3) begin
            tick();
            chk("post_rst_ov", out_valid, 1'b0);
            chk("post_rst_S", S, '0);
        end

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            ce = ($urandom_range(0, 9) != 0);
            drive($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                  $urandom_range(0, 9) == 0, 1'($urandom),
                  rnd_word(), rnd_word(), rnd_word());
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
